// File: rtl/mem_bus_pkg.sv
// Shared definitions for the mem_bus_master initiator: FSM encoding and bus constants.
package mem_bus_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam logic [3:0] MEM_STRB_READ = 4'b0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

endpackage

// File: rtl/mem_bus_timeout.sv
// Wait-cycle counter for mem_bus_master; only instantiated under MEM_BUS_MASTER_TIMEOUT_EN.
module mem_bus_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Expiry fires on the TIMEOUT_CYCLES-th not-ready cycle, so the FSM leaves REQ at that edge.
    assign expired = enable && (count == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_bus_master.sv
// Single-outstanding picorv32-native bus initiator driven by a command/response stream.
// Optional timeout support is compiled in with MEM_BUS_MASTER_TIMEOUT_EN.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [MEM_ADDR_W-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic [31:0]           mem_rdata,
    output logic [CNT_W-1:0]      txn_count,
    output logic [CNT_W-1:0]      err_count
);

    state_t state, state_next;
    logic   accept;
    logic   complete;
    logic   timeout_hit;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    // mem_ready only means something while a request is on the bus.
    assign complete  = (state == REQ) && mem_ready;

`ifdef MEM_BUS_MASTER_TIMEOUT_EN
    logic expired;

    mem_bus_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .enable ((state == REQ) && !mem_ready),
        .expired(expired)
    );

    assign timeout_hit = expired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_err   <= 1'b0;
            err_count <= '0;
        end else if (complete) begin
            rsp_err <= 1'b0;
        end else if (timeout_hit) begin
            rsp_err <= 1'b1;
            if (err_count != {CNT_W{1'b1}}) begin
                err_count <= err_count + 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
    assign err_count   = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = REQ;
            REQ:     if (complete || timeout_hit) state_next = RSP;
            RSP:     if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            txn_count <= '0;
        end else begin
            if (accept) begin
                mem_valid <= 1'b1;
                mem_addr  <= cmd_addr & ~32'h0000_0003;
                mem_wdata <= cmd_wdata;
                mem_wstrb <= cmd_wstrb;
            end
            if (complete) begin
                mem_valid <= 1'b0;
                rsp_valid <= 1'b1;
                rsp_rdata <= (mem_wstrb == MEM_STRB_READ) ? mem_rdata : 32'h0;
                txn_count <= txn_count + 1'b1;
            end else if (timeout_hit) begin
                mem_valid <= 1'b0;
                rsp_valid <= 1'b1;
                rsp_rdata <= 32'h0;
            end
            if ((state == RSP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
